// File: rtl/layered_display_compositor_if.sv
// Video/control bus of the layered display compositor.
// Groups every non-clock, non-reset signal of the compositor so the producer side and the
// compositor share one typed bundle.
//   master : drives IR code/strobe, frame pulse, counters, layer/camera/start pixels, health;
//            observes the composited pixel, delayed counters and game mode.
//   slave  : the compositor's view (directions reversed).
interface layered_display_compositor_if #(
  parameter int unsigned NUM_LAYERS = 8
);
  logic [31:0]              ir_in;
  logic                     ir_valid_in;
  logic                     nf_in;
  logic [10:0]              hcount_in;
  logic [9:0]               vcount_in;
  logic [24*NUM_LAYERS-1:0] layer_pixels_in;
  logic [NUM_LAYERS-1:0]    layer_en_in;
  logic [23:0]              start_pixel_in;
  logic [23:0]              camera_pixel_in;
  logic                     camera_en_in;
  logic [2:0]               player_health_in;
  logic [2:0]               opponent_health_in;
  logic [23:0]              pixel_out;
  logic [10:0]              hcount_out;
  logic [9:0]               vcount_out;
  logic [1:0]               mode_out;

  modport master (
    output ir_in, ir_valid_in, nf_in, hcount_in, vcount_in, layer_pixels_in, layer_en_in,
           start_pixel_in, camera_pixel_in, camera_en_in, player_health_in,
           opponent_health_in,
    input  pixel_out, hcount_out, vcount_out, mode_out
  );

  modport slave (
    input  ir_in, ir_valid_in, nf_in, hcount_in, vcount_in, layer_pixels_in, layer_en_in,
           start_pixel_in, camera_pixel_in, camera_en_in, player_health_in,
           opponent_health_in,
    output pixel_out, hcount_out, vcount_out, mode_out
  );
endinterface

// File: rtl/layered_display_compositor.sv
// Layered display compositor.
// Merges NUM_LAYERS colour-keyed sprite layers, a camera feed, a start-screen image and the
// arena border into one 24-bit pixel stream with a 2-cycle, one-pixel-per-cycle pipeline.
// A game-mode FSM (START/GAME/PAUSE/OVER) is driven by IR remote codes and health, and a
// frame-counted damage flash inverts the picture on odd counter frames.
// Ports:
//   clk_in : pixel clock
//   rst_in : synchronous, active-high reset
//   bus    : slave side of layered_display_compositor_if (IR, frame pulse, counters,
//            layer/camera/start pixels, health in; pixel, delayed counters, mode out)
module layered_display_compositor #(
  parameter int unsigned NUM_LAYERS   = 8,
  parameter logic [23:0] KEY_COLOR    = 24'h00_00_00,
  parameter logic [23:0] BG_COLOR     = 24'h00_00_00,
  parameter int unsigned BORDER_X     = 960,
  parameter int unsigned BORDER_Y     = 640,
  parameter logic [31:0] START_CODE_A = 32'h20DF_5BA4,
  parameter logic [31:0] START_CODE_B = 32'h20DF_5AA5,
  parameter logic [31:0] PAUSE_CODE   = 32'h20DF_22DD,
  parameter int unsigned FLASH_FRAMES = 8
) (
  input logic                          clk_in,
  input logic                          rst_in,
  layered_display_compositor_if.slave  bus
);

  localparam logic [10:0] BorderXW = 11'(BORDER_X);
  localparam logic [9:0]  BorderYW = 10'(BORDER_Y);
  localparam logic [7:0]  FlashInit = 8'(FLASH_FRAMES);

  typedef enum logic [1:0] {
    StStart = 2'd0,
    StGame  = 2'd1,
    StPause = 2'd2,
    StOver  = 2'd3
  } mode_e;

  // Game state
  mode_e      r_mode;
  logic [7:0] r_flash_cnt;
  logic [2:0] r_prev_health;

  // Stage 1
  logic [24*NUM_LAYERS-1:0] r_s1_layers;
  logic [NUM_LAYERS-1:0]    r_s1_en;
  logic [23:0]              r_s1_start;
  logic [23:0]              r_s1_cam;
  logic                     r_s1_cam_en;
  logic                     r_s1_border;
  mode_e                    r_s1_mode;
  logic [10:0]              r_s1_h;
  logic [9:0]               r_s1_v;

  // Stage 2
  logic [23:0] r_pixel;
  logic [10:0] r_h_out;
  logic [9:0]  r_v_out;

  logic        w_border;
  logic        w_start_code;
  logic        w_pause_code;
  logic        w_dead;
  logic [23:0] w_sel;
  logic [23:0] w_game_px;
  logic [23:0] w_mode_px;

  assign w_border = ((bus.hcount_in == BorderXW) && (bus.vcount_in <= BorderYW)) ||
                    ((bus.vcount_in == BorderYW) && (bus.hcount_in <= BorderXW));

  assign w_start_code = bus.ir_valid_in &&
                        ((bus.ir_in == START_CODE_A) || (bus.ir_in == START_CODE_B));
  assign w_pause_code = bus.ir_valid_in && (bus.ir_in == PAUSE_CODE);
  assign w_dead       = (bus.player_health_in == 3'd0) || (bus.opponent_health_in == 3'd0);

  // Mode FSM and damage-flash counter. The counter only runs in GAME and is zeroed on
  // every exit from GAME, so PAUSE/OVER never show an inverted frame.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_mode        <= StStart;
      r_flash_cnt   <= 8'd0;
      // Track the live health so the first frame after reset never flashes.
      r_prev_health <= bus.player_health_in;
    end else begin
      if (bus.nf_in) begin
        r_prev_health <= bus.player_health_in;
      end
      case (r_mode)
        StStart: begin
          if (w_start_code) r_mode <= StGame;
        end
        StGame: begin
          if (bus.nf_in && w_dead) begin
            r_mode      <= StOver;
            r_flash_cnt <= 8'd0;
          end else if (w_pause_code) begin
            r_mode      <= StPause;
            r_flash_cnt <= 8'd0;
          end else if (bus.nf_in) begin
            // Reload takes priority over the per-frame decrement.
            if (bus.player_health_in < r_prev_health) begin
              r_flash_cnt <= FlashInit;
            end else if (r_flash_cnt != 8'd0) begin
              r_flash_cnt <= r_flash_cnt - 8'd1;
            end
          end
        end
        StPause: begin
          if (w_pause_code) r_mode <= StGame;
        end
        StOver: begin
          if (w_start_code) r_mode <= StStart;
        end
        default: r_mode <= StStart;
      endcase
    end
  end

  // Stage 1: capture the pixel inputs together with the mode in force for this pixel.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_s1_layers <= '0;
      r_s1_en     <= '0;
      r_s1_start  <= 24'd0;
      r_s1_cam    <= 24'd0;
      r_s1_cam_en <= 1'b0;
      r_s1_border <= 1'b0;
      r_s1_mode   <= StStart;
      r_s1_h      <= 11'd0;
      r_s1_v      <= 10'd0;
    end else begin
      r_s1_layers <= bus.layer_pixels_in;
      r_s1_en     <= bus.layer_en_in;
      r_s1_start  <= bus.start_pixel_in;
      r_s1_cam    <= bus.camera_pixel_in;
      r_s1_cam_en <= bus.camera_en_in;
      r_s1_border <= w_border;
      r_s1_mode   <= r_mode;
      r_s1_h      <= bus.hcount_in;
      r_s1_v      <= bus.vcount_in;
    end
  end

  // Priority select: walk from the lowest-priority layer upward so index 0 wins last.
  always_comb begin
    w_sel = r_s1_cam_en ? r_s1_cam : BG_COLOR;
    for (int i = int'(NUM_LAYERS) - 1; i >= 0; i--) begin
      if (r_s1_en[i] && (r_s1_layers[24*i +: 24] != KEY_COLOR)) begin
        w_sel = r_s1_layers[24*i +: 24];
      end
    end
    if (r_s1_border) begin
      w_sel = 24'hFF_FF_FF;
    end
  end

  assign w_game_px = r_flash_cnt[0] ? ~w_sel : w_sel;

  always_comb begin
    w_mode_px = w_game_px;
    case (r_s1_mode)
      StStart: w_mode_px = r_s1_start;
      StGame:  w_mode_px = w_game_px;
      StPause: w_mode_px = {1'b0, w_sel[23:17], 1'b0, w_sel[15:9], 1'b0, w_sel[7:1]};
      StOver:  w_mode_px = {2'b0, w_sel[23:18], 2'b0, w_sel[15:10], 2'b0, w_sel[7:2]};
      default: w_mode_px = w_game_px;
    endcase
  end

  // Stage 2
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_pixel <= 24'd0;
      r_h_out <= 11'd0;
      r_v_out <= 10'd0;
    end else begin
      r_pixel <= w_mode_px;
      r_h_out <= r_s1_h;
      r_v_out <= r_s1_v;
    end
  end

  assign bus.pixel_out  = r_pixel;
  assign bus.hcount_out = r_h_out;
  assign bus.vcount_out = r_v_out;
  assign bus.mode_out   = r_mode;

endmodule
